exi_capture_slave: RTL and testbench
====================================

Name: exi_capture_slave

Overview:
- Parametrised EXI slave and bus sniffer; the successor to the single-mode byte capture block.
- Oversamples EXI sck/cs/mosi on the fabric clock, assembles WORD_W-bit words and writes them to a dual-port RAM write port.
- Can drive MISO from a host-supplied word stream and reports per-message framing and status.
- Sits between the EXI pins and the capture DPRAM / readout logic.

Parameters:
- WORD_W, 8: bits per captured word; legal range 4..32.
- ADDR_W, 8: RAM address width.
- CPOL, 0: idle sck level. 0 samples on rising edge and shifts on falling edge; 1 is the inverse. CPHA is fixed at 0.
- ADDR_MODE, 0: 0 keeps the address continuous across messages; 1 resets the address to 0 at each message start.
- SYNC_STAGES, 2: synchroniser depth for sck, cs and mosi; minimum 2.
- MISO_EN, 1: 0 ties miso_oe low, tx_req low and removes the TX shifter.

Ports:
- clk  in  1  fabric sample clock; must be at least 4x the sck frequency.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  EXI clock, asynchronous.
- cs_n  in  1  EXI chip select, active low, asynchronous.
- mosi  in  1  EXI master-out data.
- miso  out  1  EXI slave-out data.
- miso_oe  out  1  high while a message is active (MISO_EN=1).
- wr_en  out  1  RAM write strobe, one-cycle pulse.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  WORD_W  RAM write data; MSB is the first bit received.
- tx_data  in  WORD_W  next word to transmit, MSB first.
- tx_req  out  1  one-cycle pulse: tx_data is consumed at the next shift edge.
- active  out  1  registered message-active indication (LED drive).
- msg_start  out  1  one-cycle pulse on cs_n falling.
- msg_end  out  1  one-cycle pulse on cs_n rising.
- msg_words  out  ADDR_W  complete words in the last finished message, saturating.
- partial  out  1  last message ended mid-word; sticky until the next msg_start.

Behaviour:
- Reset values:
  - All outputs 0.
  - wr_addr = 0.
  - Synchroniser flops preset to idle: cs_n=1, sck=CPOL.
  - miso = 0.
- Synchronisation:
  - sck, cs_n and mosi pass through SYNC_STAGES flops, plus one history flop on sck and cs_n for edge detection.
  - mosi uses a delay equal to that of sck, so the sampled bit aligns with the detected edge.
- Edges: sample_edge is the leading edge (rising if CPOL=0); shift_edge is the trailing edge. Edges are ignored while the message is not active.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE on synchronised cs_n falling. In that cycle:
    - pulse msg_start;
    - bit_cnt = WORD_W-1;
    - word count = 0;
    - clear partial;
    - load TX shifter from tx_data;
    - if ADDR_MODE=1, wr_addr = 0.
  - ACTIVE -> IDLE on synchronised cs_n rising. In that cycle:
    - pulse msg_end;
    - msg_words = word count;
    - partial = (bit_cnt != WORD_W-1);
    - discard partial RX bits; nothing is written.
- RX path, on each sample_edge in ACTIVE:
  - rx_shift = {rx_shift[WORD_W-2:0], mosi_s}.
  - bit_cnt decrements.
  - At bit_cnt==0 the word is complete: the next cycle drives wr_en=1 with wr_data = full word and wr_addr = current address. bit_cnt reloads to WORD_W-1.
  - The cycle after wr_en, wr_addr increments modulo 2^ADDR_W and wraps silently.
  - The word counter increments and saturates at 2^ADDR_W-1.
  - Latency from the final sample_edge detection to wr_en is 1 clk.
- TX path (MISO_EN=1):
  - miso = tx_shift MSB; miso_oe = active.
  - On each shift_edge: shift left with 0 fill.
  - On the shift_edge following word completion: load tx_data instead of shifting.
  - tx_req pulses together with wr_en. tx_data must be stable from tx_req until that shift_edge.
  - In IDLE, miso holds 0.
- Simultaneous events:
  - A cs_n rising in the same cycle as a word-completing sample_edge: the word is written, msg_words includes it, and partial = 0.
  - A cs_n falling in the same cycle as an sck edge: the sck edge is ignored.
- Asynchronous reset mid-message: immediate return to IDLE and all outputs 0. The next message starts cleanly only after a cs_n falling edge seen post-reset.

Decomposition:
- Package exi_pkg holds:
  - state enum (IDLE, ACTIVE);
  - ADDR_MODE_CONT = 0, ADDR_MODE_PER_MSG = 1;
  - a function returning the sample/shift edge polarity from CPOL.
- One sub-module, exi_sync_edge: a parametrised SYNC_STAGES synchroniser with rise/fall pulse outputs. Instantiated for sck and cs_n; mosi uses its delay-only output.

Test Plan:
- Byte capture, mode 0, defaults: cs low; send 0xA5, 0x3C at clk/8; cs high.
  - Expect wr_en pulses with (addr 0, 0xA5) and (addr 1, 0x3C).
  - Expect msg_words = 2, partial = 0.
- ADDR_MODE=1: two messages of 3 words each.
  - Second message writes addresses 0..2; with ADDR_MODE=0 it writes 3..5.
- MISO echo: tx_data = 0x81 at start, then 0x7E on tx_req; 16 clocks.
  - Master samples 0x81 then 0x7E.
  - miso_oe is high only while cs_n is low.
- Partial word: 13 clocks at WORD_W=8, then cs high.
  - Exactly one write; msg_words = 1, partial = 1.
  - partial clears on the next msg_start.
- CPOL=1, WORD_W=16: send 0xBEEF.
  - One write of 0xBEEF; no activity from idle-high sck before cs falls.
- Wrap and reset: ADDR_W=4, 17 words.
  - The 17th word is written at address 0 and msg_words saturates at 15.
  - Asserting rst_n low mid-word clears all outputs, and the following message writes correctly.

Source files
------------

// File: rtl/exi_pkg.sv
// Shared types and helpers for the EXI capture slave.
package exi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } exi_state_e;

  localparam int ADDR_MODE_CONT    = 0;
  localparam int ADDR_MODE_PER_MSG = 1;

  // CPHA is fixed at 0: the leading edge samples, the trailing edge shifts.
  function automatic logic sample_on_rise(input int cpol);
    return (cpol == 0);
  endfunction

endpackage

// File: rtl/exi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with rise/fall pulses
// derived from a history flop behind the last stage.
module exi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/exi_capture_slave.sv
// EXI slave / sniffer: oversamples sck, cs_n and mosi, writes assembled words
// to a DPRAM port, optionally drives miso, and reports per-message status.
module exi_capture_slave
  import exi_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int CPOL        = 0,
  parameter int ADDR_MODE   = ADDR_MODE_CONT,
  parameter int SYNC_STAGES = 2,
  parameter int MISO_EN     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  input  logic [WORD_W-1:0] tx_data,
  output logic              tx_req,
  output logic              active,
  output logic              msg_start,
  output logic              msg_end,
  output logic [ADDR_W-1:0] msg_words,
  output logic              partial
);

  localparam int              BW       = $clog2(WORD_W);
  localparam logic [BW-1:0]   BIT_TOP  = BW'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
  logic unused_sck_s, unused_cs_s, unused_mosi_rise, unused_mosi_fall;
  logic sample_edge, shift_edge;

  // Synchronisers start in the idle bus state so reset never fakes an edge.
  exi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL != 0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .d(sck),
    .q(unused_sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  exi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d(cs_n),
    .q(unused_cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  exi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .d(mosi),
    .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  assign sample_edge = sample_on_rise(CPOL) ? sck_rise : sck_fall;
  assign shift_edge  = sample_on_rise(CPOL) ? sck_fall : sck_rise;

  exi_state_e        state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d, rx_next;
  logic              wr_en_q, wr_en_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] msg_words_q, msg_words_d;
  logic              partial_q, partial_d;
  logic              msg_start_q, msg_start_d;
  logic              msg_end_q, msg_end_d;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_d, tx_load;
  logic              tx_pend_q, tx_pend_d;
  logic              tx_req_q, tx_req_d;

  assign rx_next = {rx_shift_q[WORD_W-2:0], mosi_s};
  assign tx_load = (MISO_EN != 0) ? tx_data : '0;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    word_cnt_d  = word_cnt_q;
    msg_words_d = msg_words_q;
    partial_d   = partial_q;
    msg_start_d = 1'b0;
    msg_end_d   = 1'b0;
    tx_shift_d  = tx_shift_q;
    tx_pend_d   = tx_pend_q;
    tx_req_d    = 1'b0;

    if (wr_en_q) wr_addr_d = wr_addr_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          msg_start_d = 1'b1;
          bit_cnt_d   = BIT_TOP;
          word_cnt_d  = '0;
          partial_d   = 1'b0;
          tx_shift_d  = tx_load;
          tx_pend_d   = 1'b0;
          if (ADDR_MODE == ADDR_MODE_PER_MSG) wr_addr_d = '0;
        end
      end
      ACTIVE: begin
        if (sample_edge) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == '0) begin
            wr_en_d   = 1'b1;
            wr_data_d = rx_next;
            bit_cnt_d = BIT_TOP;
            tx_pend_d = 1'b1;
            tx_req_d  = (MISO_EN != 0);
            if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
        if (shift_edge) begin
          if (tx_pend_q) begin
            tx_shift_d = tx_load;
            tx_pend_d  = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
          end
        end
        // Uses the updated counters so a word finishing on this cycle counts.
        if (cs_rise) begin
          state_d     = IDLE;
          msg_end_d   = 1'b1;
          msg_words_d = word_cnt_d;
          partial_d   = (bit_cnt_d != BIT_TOP);
          tx_shift_d  = '0;
          tx_pend_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      word_cnt_q  <= '0;
      msg_words_q <= '0;
      partial_q   <= 1'b0;
      msg_start_q <= 1'b0;
      msg_end_q   <= 1'b0;
      tx_shift_q  <= '0;
      tx_pend_q   <= 1'b0;
      tx_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      word_cnt_q  <= word_cnt_d;
      msg_words_q <= msg_words_d;
      partial_q   <= partial_d;
      msg_start_q <= msg_start_d;
      msg_end_q   <= msg_end_d;
      tx_shift_q  <= tx_shift_d;
      tx_pend_q   <= tx_pend_d;
      tx_req_q    <= tx_req_d;
    end
  end

  assign active    = (state_q == ACTIVE);
  assign miso      = tx_shift_q[WORD_W-1];
  assign miso_oe   = (MISO_EN != 0) && (state_q == ACTIVE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign tx_req    = tx_req_q;
  assign msg_start = msg_start_q;
  assign msg_end   = msg_end_q;
  assign msg_words = msg_words_q;
  assign partial   = partial_q;

endmodule

// File: tb/tb_exi_capture_slave.sv
// Self-checking bench: four configurations of exi_capture_slave driven by an
// EXI master model and compared against a word-level reference model.
module tb_exi_capture_slave;

  localparam int HALF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sck, sck_b, cs_n, csb_n, mosi;
  logic [7:0]  tx_data;
  logic [15:0] tx_data_b;
  assign sck_b = ~sck;

  logic       miso0, miso_oe0, wr_en0, tx_req0, active0, msg_start0, msg_end0, part0;
  logic [7:0] wr_addr0, wr_data0, mw0;
  logic       miso1, miso_oe1, wr_en1, tx_req1, active1, msg_start1, msg_end1, part1;
  logic [7:0] wr_addr1, wr_data1, mw1;
  logic        miso2, miso_oe2, wr_en2, tx_req2, active2, msg_start2, msg_end2, part2;
  logic [7:0]  wr_addr2, mw2;
  logic [15:0] wr_data2;
  logic       miso3, miso_oe3, wr_en3, tx_req3, active3, msg_start3, msg_end3, part3;
  logic [3:0] wr_addr3, mw3;
  logic [7:0] wr_data3;

  exi_capture_slave u0 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso0),
    .miso_oe(miso_oe0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .tx_data(tx_data), .tx_req(tx_req0), .active(active0), .msg_start(msg_start0),
    .msg_end(msg_end0), .msg_words(mw0), .partial(part0)
  );

  exi_capture_slave #(.ADDR_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso1),
    .miso_oe(miso_oe1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .tx_data(tx_data), .tx_req(tx_req1), .active(active1), .msg_start(msg_start1),
    .msg_end(msg_end1), .msg_words(mw1), .partial(part1)
  );

  exi_capture_slave #(.CPOL(1), .WORD_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .sck(sck_b), .cs_n(csb_n), .mosi(mosi), .miso(miso2),
    .miso_oe(miso_oe2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .tx_data(tx_data_b), .tx_req(tx_req2), .active(active2), .msg_start(msg_start2),
    .msg_end(msg_end2), .msg_words(mw2), .partial(part2)
  );

  exi_capture_slave #(.ADDR_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso3),
    .miso_oe(miso_oe3), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .tx_data(tx_data), .tx_req(tx_req3), .active(active3), .msg_start(msg_start3),
    .msg_end(msg_end3), .msg_words(mw3), .partial(part3)
  );

  // Write log entries are {addr16, data16}; only this monitor appends.
  logic [31:0] wq0[$], wq1[$], wq2[$], wq3[$];
  int treq_cnt = 0, ms_cnt = 0, me_cnt = 0, ev2_cnt = 0;

  always @(negedge clk) begin
    if (wr_en0) wq0.push_back({8'h00, wr_addr0, 8'h00, wr_data0});
    if (wr_en1) wq1.push_back({8'h00, wr_addr1, 8'h00, wr_data1});
    if (wr_en2) wq2.push_back({8'h00, wr_addr2, wr_data2});
    if (wr_en3) wq3.push_back({12'h000, wr_addr3, 8'h00, wr_data3});
    if (tx_req0) treq_cnt++;
    if (msg_start0) ms_cnt++;
    if (msg_end0) me_cnt++;
    if (msg_start2 | wr_en2 | tx_req2 | active2) ev2_cnt++;
  end

  int          checks = 0, failures = 0;
  int          rd[4] = '{0, 0, 0, 0};
  int          maddr[4] = '{0, 0, 0, 0};
  logic        bits_q[$];
  logic        miso_rx[$];
  logic [7:0]  txw_q[$];
  logic [31:0] expq[$], gotq[$];
  logic [15:0] exp_mw, got_mw;
  logic        exp_part, got_part, part_mid;
  int          oe_low;

  function automatic void rand_bits(input int n);
    bits_q.delete();
    for (int i = 0; i < n; i++) bits_q.push_back(1'($urandom_range(0, 1)));
  endfunction

  function automatic void push_word(input logic [15:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endfunction

  // Reference: every complete group of W bits is one word, MSB first.
  function automatic void expect_msg(input int inst);
    int w, aw, start, nw;
    logic [15:0] d;
    w     = (inst == 2) ? 16 : 8;
    aw    = (inst == 3) ? 4 : 8;
    start = (inst == 1) ? 0 : maddr[inst];
    nw    = bits_q.size() / w;
    expq.delete();
    for (int k = 0; k < nw; k++) begin
      d = '0;
      for (int b = 0; b < w; b++) d = {d[14:0], bits_q[k*w+b]};
      expq.push_back({16'((start + k) % (1 << aw)), d});
    end
    exp_mw      = 16'((nw > (1 << aw) - 1) ? (1 << aw) - 1 : nw);
    exp_part    = (bits_q.size() % w) != 0;
    maddr[inst] = (start + nw) % (1 << aw);
  endfunction

  function automatic void fetch(input int inst);
    gotq.delete();
    case (inst)
      0: begin while (rd[0] < wq0.size()) begin gotq.push_back(wq0[rd[0]]); rd[0]++; end
               got_mw = 16'(mw0); got_part = part0; end
      1: begin while (rd[1] < wq1.size()) begin gotq.push_back(wq1[rd[1]]); rd[1]++; end
               got_mw = 16'(mw1); got_part = part1; end
      2: begin while (rd[2] < wq2.size()) begin gotq.push_back(wq2[rd[2]]); rd[2]++; end
               got_mw = 16'(mw2); got_part = part2; end
      default: begin while (rd[3] < wq3.size()) begin gotq.push_back(wq3[rd[3]]); rd[3]++; end
               got_mw = 16'(mw3); got_part = part3; end
    endcase
  endfunction

  // EXI master, sck idle low on the shared bus (u2 sees it inverted).
  task automatic send_msg(input bit use_b);
    miso_rx.delete();
    oe_low = 0;
    @(negedge clk);
    if (use_b) csb_n = 1'b0; else cs_n = 1'b0;
    for (int i = 0; i < bits_q.size(); i++) begin
      mosi = bits_q[i];
      repeat (HALF) @(negedge clk);
      miso_rx.push_back(miso0);
      if (!use_b && !miso_oe0) oe_low++;
      if (i == 0) part_mid = part0;
      sck = 1'b1;
      if (i % 8 == 7 && txw_q.size() > 0) tx_data = txw_q.pop_front();
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n  = 1'b1;
    csb_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({miso0, miso_oe0, wr_en0, wr_addr0, wr_data0, tx_req0, active0, msg_start0, msg_end0, mw0, part0} !== '0) begin
      failures++; $display("[TB] FAIL reset_u0 got=%b required=0", {miso0, miso_oe0, wr_en0, wr_addr0, wr_data0, tx_req0, active0, mw0, part0});
    end
    checks++;
    if ({miso2, miso_oe2, wr_en2, wr_addr2, wr_data2, tx_req2, active2, msg_start2, msg_end2, mw2, part2} !== '0) begin
      failures++; $display("[TB] FAIL reset_u2 got=%b required=0", {miso2, miso_oe2, wr_en2, wr_addr2, wr_data2, tx_req2, active2, mw2, part2});
    end
    checks++;
    if ({miso3, miso_oe3, wr_en3, wr_addr3, wr_data3, tx_req3, active3, msg_start3, msg_end3, mw3, part3} !== '0) begin
      failures++; $display("[TB] FAIL reset_u3 got=%b required=0", {miso3, miso_oe3, wr_en3, wr_addr3, wr_data3, tx_req3, active3, mw3, part3});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_byte_capture;
    int ms0, me0;
    ms0 = ms_cnt; me0 = me_cnt;
    bits_q.delete();
    push_word(16'h00A5, 8);
    push_word(16'h003C, 8);
    send_msg(1'b0);
    for (int inst = 0; inst < 4; inst++) begin
      if (inst == 2) continue;
      expect_msg(inst); fetch(inst);
      checks++;
      if (gotq.size() != expq.size()) begin failures++; $display("[TB] FAIL byte_u%0d_count got=%0d required=%0d", inst, gotq.size(), expq.size()); end
      for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
        checks++;
        if (gotq[k] !== expq[k]) begin failures++; $display("[TB] FAIL byte_u%0d_write%0d got=%h required=%h", inst, k, gotq[k], expq[k]); end
      end
      checks++;
      if (got_mw !== exp_mw) begin failures++; $display("[TB] FAIL byte_u%0d_msg_words got=%0d required=%0d", inst, got_mw, exp_mw); end
      checks++;
      if (got_part !== exp_part) begin failures++; $display("[TB] FAIL byte_u%0d_partial got=%b required=%b", inst, got_part, exp_part); end
    end
    checks++;
    if (ms_cnt - ms0 != 1 || me_cnt - me0 != 1) begin
      failures++; $display("[TB] FAIL byte_pulses got start=%0d end=%0d required=1,1", ms_cnt - ms0, me_cnt - me0);
    end
  endtask

  task automatic test_addr_mode;
    for (int m = 0; m < 2; m++) begin
      rand_bits(24);
      send_msg(1'b0);
      for (int inst = 0; inst < 4; inst++) begin
        if (inst == 2) continue;
        expect_msg(inst); fetch(inst);
        checks++;
        if (gotq.size() != expq.size()) begin failures++; $display("[TB] FAIL addr_u%0d_count got=%0d required=%0d", inst, gotq.size(), expq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
          checks++;
          if (gotq[k] !== expq[k]) begin failures++; $display("[TB] FAIL addr_u%0d_write%0d got=%h required=%h", inst, k, gotq[k], expq[k]); end
        end
        checks++;
        if (got_mw !== exp_mw) begin failures++; $display("[TB] FAIL addr_u%0d_msg_words got=%0d required=%0d", inst, got_mw, exp_mw); end
        checks++;
        if (got_part !== exp_part) begin failures++; $display("[TB] FAIL addr_u%0d_partial got=%b required=%b", inst, got_part, exp_part); end
      end
    end
  endtask

  task automatic test_miso_echo;
    logic [15:0] rx;
    int t0;
    t0 = treq_cnt;
    tx_data = 8'h81;
    txw_q.delete();
    txw_q.push_back(8'h7E);
    rand_bits(16);
    send_msg(1'b0);
    rx = '0;
    for (int k = 0; k < 16; k++) rx = {rx[14:0], miso_rx[k]};
    checks++;
    if (rx !== 16'h817E) begin failures++; $display("[TB] FAIL echo_miso got=%h required=817e", rx); end
    checks++;
    if (treq_cnt - t0 != 2) begin failures++; $display("[TB] FAIL echo_tx_req got=%0d required=2", treq_cnt - t0); end
    checks++;
    if (oe_low != 0) begin failures++; $display("[TB] FAIL echo_oe_low got=%0d required=0", oe_low); end
    checks++;
    if ({miso_oe0, miso0} !== 2'b00) begin failures++; $display("[TB] FAIL echo_idle got=%b required=00", {miso_oe0, miso0}); end
    for (int inst = 0; inst < 4; inst++) begin
      if (inst == 2) continue;
      expect_msg(inst); fetch(inst);
      checks++;
      if (gotq.size() != expq.size()) begin failures++; $display("[TB] FAIL echo_u%0d_count got=%0d required=%0d", inst, gotq.size(), expq.size()); end
      for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
        checks++;
        if (gotq[k] !== expq[k]) begin failures++; $display("[TB] FAIL echo_u%0d_write%0d got=%h required=%h", inst, k, gotq[k], expq[k]); end
      end
    end
  endtask

  task automatic test_partial;
    for (int m = 0; m < 2; m++) begin
      rand_bits((m == 0) ? 13 : 8);
      send_msg(1'b0);
      if (m == 1) begin
        checks++;
        if (part_mid !== 1'b0) begin failures++; $display("[TB] FAIL partial_clear got=%b required=0", part_mid); end
      end
      for (int inst = 0; inst < 4; inst++) begin
        if (inst == 2) continue;
        expect_msg(inst); fetch(inst);
        checks++;
        if (gotq.size() != expq.size()) begin failures++; $display("[TB] FAIL partial_u%0d_count got=%0d required=%0d", inst, gotq.size(), expq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
          checks++;
          if (gotq[k] !== expq[k]) begin failures++; $display("[TB] FAIL partial_u%0d_write%0d got=%h required=%h", inst, k, gotq[k], expq[k]); end
        end
        checks++;
        if (got_mw !== exp_mw) begin failures++; $display("[TB] FAIL partial_u%0d_msg_words got=%0d required=%0d", inst, got_mw, exp_mw); end
        checks++;
        if (got_part !== exp_part) begin failures++; $display("[TB] FAIL partial_u%0d_partial got=%b required=%b", inst, got_part, exp_part); end
      end
    end
  endtask

  task automatic test_cpol1;
    int ms0;
    checks++;
    if (ev2_cnt != 0) begin failures++; $display("[TB] FAIL cpol1_idle_activity got=%0d required=0", ev2_cnt); end
    ms0 = ms_cnt;
    bits_q.delete();
    push_word(16'hBEEF, 16);
    send_msg(1'b1);
    expect_msg(2); fetch(2);
    checks++;
    if (gotq.size() != 1) begin failures++; $display("[TB] FAIL cpol1_count got=%0d required=1", gotq.size()); end
    else begin
      checks++;
      if (gotq[0] !== expq[0]) begin failures++; $display("[TB] FAIL cpol1_write got=%h required=%h", gotq[0], expq[0]); end
    end
    checks++;
    if (got_mw !== exp_mw || got_part !== exp_part) begin
      failures++; $display("[TB] FAIL cpol1_status got=%0d/%b required=%0d/%b", got_mw, got_part, exp_mw, exp_part);
    end
    fetch(0);
    checks++;
    if (gotq.size() != 0 || ms_cnt != ms0) begin failures++; $display("[TB] FAIL cpol1_u0_quiet got=%0d writes required=0", gotq.size()); end
  endtask

  task automatic test_random_msgs;
    int nw, ex;
    for (int m = 0; m < 4; m++) begin
      nw = $urandom_range(0, 3);
      ex = $urandom_range(0, 7);
      if (nw == 0 && ex == 0) ex = 1;
      rand_bits(nw * 8 + ex);
      send_msg(1'b0);
      for (int inst = 0; inst < 4; inst++) begin
        if (inst == 2) continue;
        expect_msg(inst); fetch(inst);
        checks++;
        if (gotq.size() != expq.size()) begin failures++; $display("[TB] FAIL rand_u%0d_count got=%0d required=%0d", inst, gotq.size(), expq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
          checks++;
          if (gotq[k] !== expq[k]) begin failures++; $display("[TB] FAIL rand_u%0d_write%0d got=%h required=%h", inst, k, gotq[k], expq[k]); end
        end
        checks++;
        if (got_mw !== exp_mw) begin failures++; $display("[TB] FAIL rand_u%0d_msg_words got=%0d required=%0d", inst, got_mw, exp_mw); end
        checks++;
        if (got_part !== exp_part) begin failures++; $display("[TB] FAIL rand_u%0d_partial got=%b required=%b", inst, got_part, exp_part); end
      end
    end
  endtask

  task automatic test_wrap_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) maddr[i] = 0;
    for (int m = 0; m < 2; m++) begin
      if (m == 1) begin
        // Abort a message three bits in with an asynchronous reset.
        cs_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
          mosi = 1'($urandom_range(0, 1));
          repeat (HALF) @(negedge clk);
          sck = 1'b1;
          repeat (HALF) @(negedge clk);
          sck = 1'b0;
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({miso0, miso_oe0, wr_en0, wr_addr0, wr_data0, tx_req0, active0, msg_start0, msg_end0, mw0, part0} !== '0) begin
          failures++; $display("[TB] FAIL midreset_u0 got=%b required=0", {miso0, miso_oe0, wr_en0, wr_addr0, wr_data0, active0, mw0, part0});
        end
        checks++;
        if ({miso3, miso_oe3, wr_en3, wr_addr3, wr_data3, tx_req3, active3, msg_start3, msg_end3, mw3, part3} !== '0) begin
          failures++; $display("[TB] FAIL midreset_u3 got=%b required=0", {miso3, miso_oe3, wr_en3, wr_addr3, wr_data3, active3, mw3, part3});
        end
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) maddr[i] = 0;
      end
      rand_bits((m == 0) ? 17 * 8 : 8);
      send_msg(1'b0);
      for (int inst = 0; inst < 4; inst++) begin
        if (inst == 2) continue;
        expect_msg(inst); fetch(inst);
        checks++;
        if (gotq.size() != expq.size()) begin failures++; $display("[TB] FAIL wrap%0d_u%0d_count got=%0d required=%0d", m, inst, gotq.size(), expq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
          checks++;
          if (gotq[k] !== expq[k]) begin failures++; $display("[TB] FAIL wrap%0d_u%0d_write%0d got=%h required=%h", m, inst, k, gotq[k], expq[k]); end
        end
        checks++;
        if (got_mw !== exp_mw) begin failures++; $display("[TB] FAIL wrap%0d_u%0d_msg_words got=%0d required=%0d", m, inst, got_mw, exp_mw); end
        checks++;
        if (got_part !== exp_part) begin failures++; $display("[TB] FAIL wrap%0d_u%0d_partial got=%b required=%b", m, inst, got_part, exp_part); end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sck       = 1'b0;
    cs_n      = 1'b1;
    csb_n     = 1'b1;
    mosi      = 1'b0;
    tx_data   = 8'h00;
    tx_data_b = 16'h0000;
    test_reset();
    test_byte_capture();
    test_addr_mode();
    test_miso_echo();
    test_partial();
    test_cpol1();
    test_random_msgs();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
